line_fill_selector: RTL and testbench

Parametrised successor to the combinational line word selector. It sits between the memory return path and the cache/load unit. On a miss it accepts one request, assembles a cache line from memory beats that arrive in wrap-around order, and forwards the requested byte, halfword or word (sign- or zero-extended) as soon as its beat lands (critical-word-first). It then presents the completed line for the cache refill.

---
 rtl/line_fill_selector.sv | 180 ++++++++++++++++++
 tb/tb_line_fill_selector.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_selector.sv
// line_fill_selector: accepts one miss request, assembles a cache line from
// wrap-around memory beats, forwards the requested byte/half/word as soon as
// its beat lands, then holds the completed line until the consumer acks it.
//
// Handshake: req_valid/req_ready transfer a request on any rising edge where
// both are high. req_ready is high only in IDLE with reset low. mem_valid has
// no backpressure: every mem_valid cycle in FILL consumes a beat, and
// mem_valid is ignored in any other state. line_valid stays high in DONE until
// line_ack is seen with it high; line_ack is ignored otherwise.
module line_fill_selector #(
  parameter int LINE_NB_BYTES = 16,
  parameter int WORD_WIDTH    = 32,
  parameter int BEAT_WIDTH    = 32,
  localparam int LINE_WIDTH   = 8 * LINE_NB_BYTES,
  localparam int NB_BEATS     = LINE_WIDTH / BEAT_WIDTH,
  localparam int OFF_W        = $clog2(LINE_NB_BYTES),
  localparam int PTR_W        = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OFF_W-1:0]      req_offset,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [PTR_W-1:0]      req_first_beat,
  input  logic                  mem_valid,
  input  logic [BEAT_WIDTH-1:0] mem_data,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_misaligned,
  output logic                  line_valid,
  output logic [LINE_WIDTH-1:0] line_data,
  input  logic                  line_ack,
  output logic [1:0]            dbg_state_o
);

  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int BB_W       = $clog2(BEAT_BYTES);
  localparam int CNT_W      = $clog2(NB_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  word_valid_q, word_valid_d;
  logic                  word_mis_q, word_mis_d;
  logic [WORD_WIDTH-1:0] word_data_q, word_data_d;

  logic                  req_mis;
  logic [PTR_W-1:0]      tgt_slot;
  logic [BB_W-1:0]       byte_sel;
  logic [BEAT_WIDTH-1:0] beat_shifted;
  logic [31:0]           field;
  logic [WORD_WIDTH-1:0] ext_data;

  // Beat slot that holds the requested bytes, and the byte position inside it.
  // An aligned access of at most 4 bytes never straddles a beat.
  assign tgt_slot     = PTR_W'(off_q >> BB_W);
  assign byte_sel     = off_q[BB_W-1:0];
  assign beat_shifted = mem_data >> {byte_sel, 3'b000};
  assign field        = beat_shifted[31:0];

  // Misalignment of the incoming request: offset not a multiple of the size.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_offset[0];
      default: req_mis = |req_offset[1:0];
    endcase
  end

  // Extract and extend the requested field from the incoming beat.
  always_comb begin
    ext_data = '0;
    case (size_q)
      2'd0:    ext_data = {{(WORD_WIDTH-8){signed_q & field[7]}}, field[7:0]};
      2'd1:    ext_data = {{(WORD_WIDTH-16){signed_q & field[15]}}, field[15:0]};
      default: ext_data = WORD_WIDTH'(field);
    endcase
  end

  // Next-state and datapath updates for IDLE/FILL/DONE.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    word_valid_d = 1'b0;
    word_mis_d   = 1'b0;
    word_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d    = req_offset;
          size_d   = req_size;
          signed_d = req_signed;
          ptr_d    = req_first_beat;
          cnt_d    = '0;
          if (req_mis) begin
            // Reject immediately; no fill is started.
            word_valid_d = 1'b1;
            word_mis_d   = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (mem_valid) begin
          line_d[ptr_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_data;
          ptr_d = (ptr_q == PTR_W'(NB_BEATS - 1)) ? '0 : ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (ptr_q == tgt_slot) begin
            word_valid_d = 1'b1;
            word_data_d  = ext_data;
          end
          if (cnt_q == CNT_W'(NB_BEATS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (line_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      word_valid_q <= 1'b0;
      word_mis_q   <= 1'b0;
      word_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      word_valid_q <= word_valid_d;
      word_mis_q   <= word_mis_d;
      word_data_q  <= word_data_d;
    end
  end

  assign req_ready       = (state_q == ST_IDLE) && !reset;
  assign line_valid      = (state_q == ST_DONE);
  assign line_data       = line_q;
  assign word_valid      = word_valid_q;
  assign word_misaligned = word_mis_q;
  assign word_data       = word_data_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_line_fill_selector.sv
// Bench for line_fill_selector: directed scenarios with literal expectations,
// plus a byte-level reference model compared against the DUT every cycle.
module tb_line_fill_selector;

  localparam int LINE_NB_BYTES = 16;
  localparam int WORD_WIDTH    = 32;
  localparam int BEAT_WIDTH    = 32;
  localparam int LINE_WIDTH    = 128;
  localparam int NB_BEATS      = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_offset;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [1:0]            req_first_beat;
  logic                  mem_valid;
  logic [BEAT_WIDTH-1:0] mem_data;
  logic                  word_valid;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_misaligned;
  logic                  line_valid;
  logic [LINE_WIDTH-1:0] line_data;
  logic                  line_ack;
  logic [1:0]            dbg_state;

  line_fill_selector #(
    .LINE_NB_BYTES(LINE_NB_BYTES),
    .WORD_WIDTH(WORD_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_offset(req_offset),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_first_beat(req_first_beat),
    .mem_valid(mem_valid),
    .mem_data(mem_data),
    .word_valid(word_valid),
    .word_data(word_data),
    .word_misaligned(word_misaligned),
    .line_valid(line_valid),
    .line_data(line_data),
    .line_ack(line_ack),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for request, 1 collecting beats, 2 line complete
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_left  = 0;
  int          m_off   = 0;
  int          m_size  = 0;
  int          m_sb    = 1;
  bit          m_sgn   = 1'b0;
  logic [7:0]  m_bytes [LINE_NB_BYTES];
  bit          e_wv    = 1'b0;
  bit          e_mis   = 1'b0;
  logic [31:0] e_wd    = '0;

  function automatic logic [LINE_WIDTH-1:0] m_line();
    logic [LINE_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < LINE_NB_BYTES; k++) v[8*k +: 8] = m_bytes[k];
    return v;
  endfunction

  function automatic logic [31:0] m_extract(input int off, input int size, input bit sgn);
    int n;
    logic [31:0] v;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = m_bytes[off + i];
    if (sgn && n < 4 && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    for (int k = 0; k < LINE_NB_BYTES; k++) m_bytes[k] = 8'h00;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0;
        e_wv    = 1'b0;
        e_mis   = 1'b0;
        e_wd    = '0;
        for (int k = 0; k < LINE_NB_BYTES; k++) m_bytes[k] = 8'h00;
      end else begin
        e_wv  = 1'b0;
        e_mis = 1'b0;
        e_wd  = '0;
        case (m_phase)
          0: if (req_valid) begin
            m_size = int'(req_size);
            m_sb   = (m_size == 0) ? 1 : (m_size == 1) ? 2 : 4;
            m_off  = int'(req_offset);
            m_sgn  = req_signed;
            if (m_off % m_sb != 0) begin
              e_wv  = 1'b1;
              e_mis = 1'b1;
            end else begin
              m_ptr   = int'(req_first_beat);
              m_left  = NB_BEATS;
              m_phase = 1;
            end
          end
          1: if (mem_valid) begin
            for (int b = 0; b < 4; b++) m_bytes[m_ptr*4 + b] = mem_data[8*b +: 8];
            if (m_ptr == m_off / 4) begin
              e_wv = 1'b1;
              e_wd = m_extract(m_off, m_size, m_sgn);
            end
            m_ptr  = (m_ptr + 1) % NB_BEATS;
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
          end
          default: if (line_ack) m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("req_ready", req_ready, (m_phase == 0) && !reset);
    check("line_valid", line_valid, m_phase == 2);
    check("line_data", line_data, m_line());
    check("word_valid", word_valid, e_wv);
    check("word_misaligned", word_misaligned, e_mis);
    if (e_wv || reset) check("word_data", word_data, e_wd);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int off, input int size, input bit sgn, input int first);
    req_valid      = 1'b1;
    req_offset     = 4'(off);
    req_size       = 2'(size);
    req_signed     = sgn;
    req_first_beat = 2'(first);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    mem_valid = 1'b1;
    mem_data  = d;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

  // Request with first beat in slot 1 holding 0x11228033, then the rest.
  task automatic slot1_fill(input string name, input int off, input int size,
                            input bit sgn, input logic [31:0] exp_word);
    send_req(off, size, sgn, 1);
    send_beat(32'h11228033);
    check({name, "_valid"}, word_valid, 1'b1);
    check({name, "_data"}, word_data, exp_word);
    send_beat(32'h22222222);
    tick();
    send_beat(32'h33333333);
    send_beat(32'h00000000);
    check({name, "_line_valid"}, line_valid, 1'b1);
    do_ack();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    req_valid      = 1'b0;
    req_offset     = '0;
    req_size       = '0;
    req_signed     = 1'b0;
    req_first_beat = '0;
    mem_valid      = 1'b0;
    mem_data       = '0;
    line_ack       = 1'b0;

    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_line_data", line_data, 128'h0);
    check("rst_word_data", word_data, 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_req_ready", req_ready, 1'b1);

    // 1: word at offset 8, first beat slot 2 (critical word first)
    send_req(8, 2, 1'b0, 2);
    check("t1_ready_in_fill", req_ready, 1'b0);
    send_beat(32'hAAAA0002);
    check("t1_word_valid", word_valid, 1'b1);
    check("t1_word_data", word_data, 32'hAAAA0002);
    send_beat(32'hBBBB0003);
    check("t1_single_pulse", word_valid, 1'b0);
    send_beat(32'hCCCC0000);
    send_beat(32'hDDDD0001);
    check("t1_line_valid", line_valid, 1'b1);
    check("t1_line_data", line_data, 128'hBBBB0003_AAAA0002_DDDD0001_CCCC0000);
    do_ack();
    check("t1_ack_ready", req_ready, 1'b1);
    check("t1_ack_line_valid", line_valid, 1'b0);

    // 2: byte signed/unsigned at offset 5, half signed at offset 6
    slot1_fill("t2_byte_s", 5, 0, 1'b1, 32'hFFFFFF80);
    slot1_fill("t2_byte_u", 5, 0, 1'b0, 32'h00000080);
    slot1_fill("t2_half_s", 6, 1, 1'b1, 32'h00001122);

    // 3: misaligned half at offset 3
    send_req(3, 1, 1'b0, 0);
    check("t3_mis_valid", word_valid, 1'b1);
    check("t3_mis_flag", word_misaligned, 1'b1);
    check("t3_mis_data", word_data, 32'h0);
    check("t3_mis_ready", req_ready, 1'b1);
    send_beat(32'hDEADBEEF);
    send_beat(32'hFEEDFACE);
    check("t3_line_kept", line_data, 128'h33333333_22222222_11228033_00000000);
    check("t3_no_line", line_valid, 1'b0);

    // 4: DONE holds the line against stray beats and requests
    send_req(0, 2, 1'b0, 0);
    send_beat(32'h00000010);
    check("t4_word_data", word_data, 32'h00000010);
    send_beat(32'h00000011);
    send_beat(32'h00000012);
    send_beat(32'h00000013);
    for (int i = 0; i < 5; i++) begin
      req_valid      = 1'b1;
      req_offset     = 4'(i * 4);
      req_size       = 2'd2;
      req_first_beat = 2'(i);
      mem_valid      = 1'b1;
      mem_data       = $urandom;
      tick();
      check("t4_hold_line", line_data, 128'h00000013_00000012_00000011_00000010);
      check("t4_hold_ready", req_ready, 1'b0);
      check("t4_hold_valid", line_valid, 1'b1);
    end
    req_valid = 1'b0;
    mem_valid = 1'b0;
    do_ack();
    check("t4_ack_ready", req_ready, 1'b1);

    // 5: reset after two of four beats, then a fresh request at offset 12
    send_req(4, 2, 1'b0, 1);
    send_beat(32'h01234567);
    send_beat(32'h89ABCDEF);
    reset = 1'b1;
    #1;
    check("t5_rst_word_valid", word_valid, 1'b0);
    check("t5_rst_line_valid", line_valid, 1'b0);
    check("t5_rst_line_data", line_data, 128'h0);
    check("t5_rst_req_ready", req_ready, 1'b0);
    check("t5_rst_word_data", word_data, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    send_req(12, 2, 1'b1, 3);
    send_beat(32'h80000001);
    check("t5_word_valid", word_valid, 1'b1);
    check("t5_word_data", word_data, 32'h80000001);
    send_beat(32'h000000A0);
    send_beat(32'h000000A1);
    send_beat(32'h000000A2);
    check("t5_line_data", line_data, 128'h80000001_000000A2_000000A1_000000A0);
    do_ack();

    // 6: target beat is the last beat, line_ack held high
    line_ack = 1'b1;
    send_req(12, 2, 1'b0, 0);
    send_beat(32'h000000B0);
    send_beat(32'h000000B1);
    send_beat(32'h000000B2);
    send_beat(32'hCAFEF00D);
    check("t6_word_valid", word_valid, 1'b1);
    check("t6_line_valid", line_valid, 1'b1);
    check("t6_word_data", word_data, 32'hCAFEF00D);
    tick();
    check("t6_idle_ready", req_ready, 1'b1);
    check("t6_line_dropped", line_valid, 1'b0);
    check("t6_pulse_over", word_valid, 1'b0);
    line_ack = 1'b0;

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
